// File: rtl/bird_pkg.sv
// Shared definitions for the bird vertical-motion engine and its neighbours.
//   HEIGHT_W / VEL_W : widths of the sprite top-y and signed velocity
//   state_e          : motion engine states IDLE, FLY, FROZEN
//   *_DEF            : default tuning constants used as parameter defaults
//   CEIL_H / FLOOR_H : play-field bounds used by the downstream death check
package bird_pkg;

   localparam int HEIGHT_W = 9;
   localparam int VEL_W    = 6;
   localparam int CD_W     = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FLY    = 2'd1,
      FROZEN = 2'd2
   } state_e;

   localparam int START_H_DEF  = 200;
   localparam int GRAVITY_DEF  = 1;
   localparam int FLAP_VEL_DEF = -6;
   localparam int MAX_FALL_DEF = 7;
   localparam int COOLDOWN_DEF = 4;

   localparam int CEIL_H  = 10;
   localparam int FLOOR_H = 420;

endpackage

// File: rtl/flap_edge.sv
// Flap button edge detector with a pending latch.
// Optional macro BIRD_FLAP_COOLDOWN_EN adds a lockout counter that discards
// rising edges for COOLDOWN frame ticks after a flap is consumed.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   flap       : debounced button level
//   fly_tick   : a frame tick is being applied in FLY (consumes the flap)
//   clr        : drop any pending flap (in IDLE or leaving for IDLE)
//   rise       : raw rising edge of flap this cycle
//   flap_now   : a flap is pending or an accepted edge arrives this cycle
module flap_edge
   import bird_pkg::*;
`ifdef BIRD_FLAP_COOLDOWN_EN
#(
   parameter int COOLDOWN = COOLDOWN_DEF
)
`endif
(
   input  logic clk,
   input  logic reset,
   input  logic flap,
   input  logic fly_tick,
   input  logic clr,
   output logic rise,
   output logic flap_now
);

   logic flap_q, flap_d;
   logic pend_q, pend_d;
   logic acc;

`ifdef BIRD_FLAP_COOLDOWN_EN
   logic [CD_W-1:0] cd_q, cd_d;

   if (COOLDOWN < 0 || COOLDOWN > 7) begin : g_bad_cooldown
      $error("COOLDOWN must fit in 3 bits");
   end
`endif

   always_comb begin
      flap_d = flap;
      rise   = flap & ~flap_q;
`ifdef BIRD_FLAP_COOLDOWN_EN
      acc    = rise & (cd_q == '0);
`else
      acc    = rise;
`endif
      flap_now = pend_q | acc;

      // A tick consumes the pending flap whether or not one was pending;
      // an edge landing on that same tick is folded into flap_now.
      pend_d = pend_q;
      if (clr)           pend_d = 1'b0;
      else if (fly_tick) pend_d = 1'b0;
      else if (acc)      pend_d = 1'b1;

`ifdef BIRD_FLAP_COOLDOWN_EN
      cd_d = cd_q;
      if (clr) begin
         cd_d = '0;
      end else if (fly_tick) begin
         if (flap_now)          cd_d = CD_W'(COOLDOWN);
         else if (cd_q != '0)   cd_d = cd_q - 3'd1;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         flap_q <= 1'b0;
         pend_q <= 1'b0;
`ifdef BIRD_FLAP_COOLDOWN_EN
         cd_q   <= '0;
`endif
      end else begin
         flap_q <= flap_d;
         pend_q <= pend_d;
`ifdef BIRD_FLAP_COOLDOWN_EN
         cd_q   <= cd_d;
`endif
      end
   end

endmodule

// File: rtl/bird_motion.sv
// Vertical motion engine for the player sprite. Integrates a signed velocity
// under constant gravity once per frame tick; a flap loads an upward velocity.
// Height is the screen y of the sprite top (0 = top, growing downward),
// saturated to 0..511.
// Optional macro BIRD_FLAP_COOLDOWN_EN enables flap lockout (see flap_edge).
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   frame_tick : one-cycle pulse per video frame
//   flap       : debounced button level
//   start      : one-cycle pulse, begin or restart the game
//   is_dead    : death flag from the downstream death check
//   height     : registered sprite top y, unsigned 9 bits
//   velocity   : registered signed velocity, 6 bits
//   flying     : high only in FLY
module bird_motion
   import bird_pkg::*;
#(
   parameter int START_H  = START_H_DEF,
   parameter int GRAVITY  = GRAVITY_DEF,
   parameter int FLAP_VEL = FLAP_VEL_DEF,
   parameter int MAX_FALL = MAX_FALL_DEF
`ifdef BIRD_FLAP_COOLDOWN_EN
   ,
   parameter int COOLDOWN = COOLDOWN_DEF
`endif
)(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       frame_tick,
   input  logic                       flap,
   input  logic                       start,
   input  logic                       is_dead,
   output logic [HEIGHT_W-1:0]        height,
   output logic signed [VEL_W-1:0]    velocity,
   output logic                       flying
);

   localparam int SUM_W = HEIGHT_W + 2;
   localparam int VX_W  = VEL_W + 2;

   if (START_H < 0 || START_H > 511) begin : g_bad_start
      $error("START_H must be within 0..511");
   end
   if (GRAVITY < 0 || GRAVITY > 31) begin : g_bad_gravity
      $error("GRAVITY must be within 0..31");
   end
   if (FLAP_VEL >= 0 || FLAP_VEL < -32) begin : g_bad_flap
      $error("FLAP_VEL must be negative and at least -32");
   end
   if (MAX_FALL <= 0 || MAX_FALL > 31) begin : g_bad_max_fall
      $error("MAX_FALL must be within 1..31");
   end

   // Clamp a wide signed height sum to the 0..511 screen range.
   function automatic logic [HEIGHT_W-1:0] sat_height(input logic signed [SUM_W-1:0] s);
      if (s < 0)                          return '0;
      else if (s > $signed(SUM_W'(511)))  return '1;
      else                                return s[HEIGHT_W-1:0];
   endfunction

   // Next velocity: flap load, else gravity capped at terminal fall speed.
   function automatic logic signed [VEL_W-1:0] next_vel(input logic signed [VEL_W-1:0] v,
                                                         input logic do_flap);
      logic signed [VX_W-1:0] inc;
      inc = $signed({{2{v[VEL_W-1]}}, v}) + $signed(VX_W'(GRAVITY));
      if (do_flap)                              return VEL_W'(FLAP_VEL);
      else if (inc > $signed(VX_W'(MAX_FALL)))  return VEL_W'(MAX_FALL);
      else                                      return inc[VEL_W-1:0];
   endfunction

   state_e                   state_q, state_d;
   logic [HEIGHT_W-1:0]      height_q, height_d;
   logic signed [VEL_W-1:0]  vel_q, vel_d;
   logic                     flying_q, flying_d;

   logic                     rise, flap_now, fly_tick, clr;
   logic signed [VEL_W-1:0]  vel_n;
   logic signed [SUM_W-1:0]  h_sum;

   // Any start either leaves for IDLE or (from IDLE) launches with no
   // pending flap, so it always clears the latch, as does sitting in IDLE.
   assign clr = (state_q == IDLE) | start;

   flap_edge
`ifdef BIRD_FLAP_COOLDOWN_EN
      #(.COOLDOWN(COOLDOWN))
`endif
   u_flap_edge (
      .clk      (clk),
      .reset    (reset),
      .flap     (flap),
      .fly_tick (fly_tick),
      .clr      (clr),
      .rise     (rise),
      .flap_now (flap_now)
   );

   always_comb begin
      vel_n = next_vel(vel_q, flap_now);
      h_sum = $signed({2'b00, height_q})
            + $signed({{(SUM_W-VEL_W){vel_n[VEL_W-1]}}, vel_n});

      state_d  = state_q;
      height_d = height_q;
      vel_d    = vel_q;
      fly_tick = 1'b0;

      case (state_q)
         IDLE: begin
            height_d = HEIGHT_W'(START_H);
            vel_d    = '0;
            if (start | rise) state_d = FLY;
         end
         FLY: begin
            if (start) begin
               state_d  = IDLE;
               height_d = HEIGHT_W'(START_H);
               vel_d    = '0;
            end else if (is_dead) begin
               state_d  = FROZEN;
            end else if (frame_tick) begin
               fly_tick = 1'b1;
               vel_d    = vel_n;
               height_d = sat_height(h_sum);
            end
         end
         FROZEN: begin
            if (start) begin
               state_d  = IDLE;
               height_d = HEIGHT_W'(START_H);
               vel_d    = '0;
            end
         end
         default: begin
            state_d  = IDLE;
            height_d = HEIGHT_W'(START_H);
            vel_d    = '0;
         end
      endcase

      flying_d = (state_d == FLY);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         height_q <= HEIGHT_W'(START_H);
         vel_q    <= '0;
         flying_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         height_q <= height_d;
         vel_q    <= vel_d;
         flying_q <= flying_d;
      end
   end

   assign height   = height_q;
   assign velocity = vel_q;
   assign flying   = flying_q;

endmodule

// File: tb/tb_bird_motion.sv
// Self-checking bench for bird_motion: directed scenarios plus randomized
// stimulus compared cycle by cycle against a behavioural game model.
module tb_bird_motion;

   logic              clk = 1'b0;
   logic              reset, frame_tick, flap, start, is_dead;
   logic [8:0]        height;
   logic signed [5:0] velocity;
   logic              flying;

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural model: game mode, position, speed, flap memory.
   localparam int M_IDLE = 0, M_FLY = 1, M_FROZEN = 2;
   int m_mode, m_h, m_v, m_cd;
   bit m_pend, m_prev;

   bird_motion dut (
      .clk        (clk),
      .reset      (reset),
      .frame_tick (frame_tick),
      .flap       (flap),
      .start      (start),
      .is_dead    (is_dead),
      .height     (height),
      .velocity   (velocity),
      .flying     (flying)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   task automatic model_go_idle();
      m_mode = M_IDLE; m_h = 200; m_v = 0; m_pend = 0; m_cd = 0;
   endtask

   task automatic model_update(input bit rst, input bit tk, input bit fl,
                               input bit st, input bit dead);
      bit rise, acc, use_flap;
      rise = fl && !m_prev;
`ifdef BIRD_FLAP_COOLDOWN_EN
      acc = rise && (m_cd == 0);
`else
      acc = rise;
`endif
      if (rst) begin
         model_go_idle();
         m_prev = 0;
         return;
      end
      m_prev = fl;
      if (m_mode == M_IDLE) begin
         if (st || rise) m_mode = M_FLY;
         m_pend = 0;
      end else if (st) begin
         model_go_idle();
      end else if (m_mode == M_FLY && dead) begin
         m_mode = M_FROZEN;
      end else if (m_mode == M_FLY && tk) begin
         use_flap = m_pend || acc;
         if (use_flap) m_v = -6;
         else          m_v = (m_v + 1 > 7) ? 7 : m_v + 1;
         m_h = m_h + m_v;
         if (m_h < 0)   m_h = 0;
         if (m_h > 511) m_h = 511;
         if (use_flap)       m_cd = 4;
         else if (m_cd > 0)  m_cd = m_cd - 1;
         m_pend = 0;
      end else if (m_mode == M_FLY && acc) begin
         m_pend = 1;
      end
   endtask

   // Apply one cycle of inputs, advance the model, compare after the edge.
   task automatic step(input bit rst, input bit tk, input bit fl,
                       input bit st, input bit dead);
      reset = rst; frame_tick = tk; flap = fl; start = st; is_dead = dead;
      @(posedge clk);
      model_update(rst, tk, fl, st, dead);
      #1;
      check_val("model_height",   int'(height),   m_h);
      check_val("model_velocity", int'(velocity), m_v);
      check_val("model_flying",   int'(flying),   (m_mode == M_FLY) ? 1 : 0);
   endtask

   task automatic restart();
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0);
   endtask

   initial begin
      int exp_h;
      bit fl_r;
      m_prev = 0;
      model_go_idle();
      reset = 1; frame_tick = 0; flap = 0; start = 0; is_dead = 0;

      // Reset state
      step(1, 0, 0, 0, 0);
      step(1, 1, 1, 1, 0);
      check_val("reset_height", int'(height), 200);
      check_val("reset_vel",    int'(velocity), 0);
      check_val("reset_flying", int'(flying), 0);

      // Start then three free-fall ticks
      step(0, 0, 0, 1, 0);
      check_val("start_flying", int'(flying), 1);
      exp_h = 200;
      for (int k = 1; k <= 3; k++) begin
         step(0, 1, 0, 0, 0);
         exp_h += k;
         check_val("fall_vel", int'(velocity), k);
         check_val("fall_h",   int'(height), exp_h);
      end

      // Flap edge then tick, then a plain tick
      step(0, 0, 1, 0, 0);
      step(0, 1, 1, 0, 0);
      check_val("flap_vel", int'(velocity), -6);
      check_val("flap_h",   int'(height), 200);
      step(0, 1, 0, 0, 0);
      check_val("after_flap_vel", int'(velocity), -5);
      check_val("after_flap_h",   int'(height), 195);

      // Reset mid-flight coinciding with a tick
      step(1, 1, 0, 0, 0);
      check_val("midreset_h",      int'(height), 200);
      check_val("midreset_vel",    int'(velocity), 0);
      check_val("midreset_flying", int'(flying), 0);

      // Terminal velocity over 10 ticks
      step(0, 0, 0, 1, 0);
      for (int k = 1; k <= 10; k++) begin
         step(0, 1, 0, 0, 0);
         check_val("terminal_vel", int'(velocity), (k > 7) ? 7 : k);
      end
      check_val("terminal_h", int'(height), 249);

      // Two edges between ticks count as a single flap
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      check_val("double_edge_vel", int'(velocity), -6);
      step(0, 1, 0, 0, 0);
      check_val("double_edge_next", int'(velocity), -5);

      // Ceiling clamp at 0, then freeze and restart
      restart();
      for (int k = 0; k < 40; k++) begin
         step(0, 0, 1, 0, 0);
         step(0, 1, 0, 0, 0);
      end
      check_val("top_clamp_h",   int'(height), 0);
      check_val("top_clamp_vel", int'(velocity), -6);
      step(0, 1, 0, 0, 1);
      check_val("frozen_flying", int'(flying), 0);
      check_val("frozen_h",      int'(height), 0);
      step(0, 1, 1, 0, 1);
      check_val("frozen_hold_h", int'(height), 0);
      step(0, 0, 0, 1, 1);
      check_val("restart_h",   int'(height), 200);
      check_val("restart_vel", int'(velocity), 0);

      // Bottom clamp at 511
      step(0, 0, 0, 1, 0);
      for (int k = 0; k < 60; k++) step(0, 1, 0, 0, 0);
      check_val("bottom_clamp_h",   int'(height), 511);
      check_val("bottom_clamp_vel", int'(velocity), 7);

`ifdef BIRD_FLAP_COOLDOWN_EN
      // Cooldown lockout
      restart();
      step(0, 0, 1, 0, 0);
      step(0, 1, 0, 0, 0);
      check_val("cd_first", int'(velocity), -6);
      for (int k = 1; k <= 4; k++) begin
         step(0, 0, 1, 0, 0);
         step(0, 1, 0, 0, 0);
         check_val("cd_locked", int'(velocity), -6 + k);
      end
      step(0, 0, 1, 0, 0);
      step(0, 1, 0, 0, 0);
      check_val("cd_release", int'(velocity), -6);
`endif

      // Randomized play against the model
      restart();
      fl_r = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(3) == 0) fl_r = ~fl_r;
         step($urandom_range(199) == 0,
              $urandom_range(2) == 0,
              fl_r,
              $urandom_range(59) == 0,
              $urandom_range(39) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/bird_motion.md
Name: bird_motion

Overview:
- Vertical motion engine for the player sprite; sits directly upstream of the death check and produces the 9-bit top-height value it consumes.
- Integrates a signed velocity under constant gravity once per frame tick. A flap press sets an upward velocity.
- Freezes when the death check reports is_dead. Returns to the start position on start.
- Height is the screen y of the sprite top edge: 0 = top, increasing downward.

Parameters:
- START_H, 200, height loaded at reset and on entering IDLE.
- GRAVITY, 1, velocity increment per tick, unsigned.
- FLAP_VEL, -6, velocity loaded on flap, signed, must be negative.
- MAX_FALL, 7, terminal downward velocity, positive.
- COOLDOWN, 4, ticks of flap lockout; only used with BIRD_FLAP_COOLDOWN_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- frame_tick  in  1  one-cycle pulse per video frame
- flap  in  1  debounced button level
- start  in  1  one-cycle pulse; begin or restart the game
- is_dead  in  1  death flag from the downstream death check
- height  out  9  sprite top y, unsigned, registered
- velocity  out  6  signed two's complement, registered
- flying  out  1  high only in FLY

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE, height=START_H, velocity=0, flying=0, flap_pending=0, flap_q=0. Reset overrides every other input in the same cycle, including mid-flight.
- Flap capture:
  - flap_q registers flap; a rising edge is flap & ~flap_q.
  - A rising edge sets flap_pending. It stays set until consumed by a FLY tick or cleared on entering IDLE.
  - A rising edge in the same cycle as a tick is consumed by that tick.
  - Multiple edges between ticks count as one flap.
- States:
  - IDLE:
    - height=START_H, velocity=0.
    - On start, or a flap rising edge, go to FLY. An edge that triggers this transition is not kept as pending.
  - FLY, on a frame_tick cycle:
    - If a flap is pending (or an edge arrives this cycle): vel_n = FLAP_VEL.
    - Otherwise: vel_n = min(velocity + GRAVITY, MAX_FALL).
    - h_n = height + vel_n, computed in 11-bit signed and saturated to 0..511.
    - velocity <= vel_n and height <= h_n in the same edge. Registered outputs change the cycle after the tick.
    - Non-tick cycles: hold.
  - FLY exits:
    - is_dead=1 → FROZEN. This takes priority over a tick in the same cycle; no update on that cycle.
    - start in FLY → IDLE.
  - FROZEN:
    - height and velocity hold; ticks and flaps are ignored.
    - start → IDLE. is_dead may remain high while in FROZEN.
- Priority, highest first: reset > start > is_dead > frame_tick.
- flying = (state==FLY), registered with the state.
- Arithmetic:
  - velocity range -32..31; parameters are checked by elaboration-time asserts.
  - Negative sums saturate to 0; sums above 511 saturate to 511.

Optional Feature:
- Macro: BIRD_FLAP_COOLDOWN_EN.
- Defined:
  - A 3-bit cooldown counter loads COOLDOWN when a flap is consumed.
  - The counter decrements on each FLY tick while nonzero.
  - Rising edges while it is nonzero are discarded and do not set flap_pending.
  - The counter clears on reset and on entering IDLE.
- Undefined: no counter; every edge is accepted.

Decomposition:
- Package bird_pkg holds:
  - HEIGHT_W=9, VEL_W=6.
  - State enum {IDLE, FLY, FROZEN}.
  - Default START_H, GRAVITY, FLAP_VEL, MAX_FALL constants, shared with the death-check bounds (10, 420).
- One natural sub-module: flap_edge, the edge detector plus pending latch (plus cooldown under the macro).
- Integration and saturation stay in bird_motion.

Test Plan:
- Reset, then start, then 3 ticks with no flap → velocity 1,2,3; height 201,203,206; flying=1.
- From height 206 with velocity 3: flap edge, then tick → velocity -6, height 200. Next tick with no flap → velocity -5, height 195.
- 10 ticks with no flap from START_H → velocity reaches 7 at tick 7 and stays 7; height 200+1+2+…+7+7+7+7 = 249.
- Height 3, velocity 0: flap, then tick → height 0, not wrapped. is_dead=1 in the same cycle as the next tick → FROZEN, height stays 0. Then start → IDLE, height 200, velocity 0.
- reset pulse mid-flight at height 310 with a tick in the same cycle → height 200, velocity 0, IDLE next cycle. Two flap edges between ticks → only one FLAP_VEL load.
- With BIRD_FLAP_COOLDOWN_EN: flap consumed, then flaps before each of the next 4 ticks → all ignored, velocity -5,-4,-3,-2. A flap before the 5th tick → velocity -6.
